hue_pwm_driver: RTL



---
 rtl/hue_pwm_driver.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hue_pwm_driver.sv
// RGB hue-wheel LED driver: hue sequencer, brightness scaling and three PWM
// channels sharing one period counter; duty registers reload only at period ends.
module hue_pwm_driver #(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned STEPS        = 200,
    parameter int unsigned STEP_PERIODS = 50,
    parameter int unsigned BRIGHT_W     = 8,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       hold,
    input  logic [BRIGHT_W-1:0]        brightness,
    output logic                       RGB_R,
    output logic                       RGB_G,
    output logic                       RGB_B,
    output logic [2:0]                 segment,
    output logic [$clog2(STEPS)-1:0]   hue_step,
    output logic                       period_tick
);

    localparam int unsigned CW    = $clog2(PWM_INTERVAL);
    localparam int unsigned RW    = $clog2(PWM_INTERVAL + 1);
    localparam int unsigned PW    = RW + BRIGHT_W;
    localparam int unsigned HW    = $clog2(STEPS);
    localparam int unsigned SW    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int unsigned LSTEP = PWM_INTERVAL / STEPS;
    localparam logic        AL    = (ACTIVE_LOW != 0);

    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_sdiv;
    logic [HW-1:0] r_step;
    logic [2:0]    r_seg;
    logic [RW-1:0] r_duty_r, r_duty_g, r_duty_b;
    logic          r_rgb_r, r_rgb_g, r_rgb_b;

    logic          w_tick;
    logic          w_sdiv_wrap, w_step_wrap;
    logic [RW-1:0] w_up, w_down, w_max;
    logic [RW-1:0] w_raw_r, w_raw_g, w_raw_b;
    logic [RW-1:0] w_tgt_r, w_tgt_g, w_tgt_b;
    logic          w_on_r, w_on_g, w_on_b;

    // Scale a raw level by brightness; all-ones passes the raw level unchanged.
    function automatic logic [RW-1:0] f_scale(input logic [RW-1:0] raw,
                                              input logic [BRIGHT_W-1:0] bright);
        logic [PW-1:0] prod;
        prod = PW'(raw) * PW'(bright);
        if (&bright)
            return raw;
        return RW'(prod >> BRIGHT_W);
    endfunction

    assign w_tick      = en && (r_cnt == CW'(PWM_INTERVAL - 1));
    assign w_sdiv_wrap = (r_sdiv == SW'(STEP_PERIODS - 1));
    assign w_step_wrap = (r_step == HW'(STEPS - 1));

    assign w_max  = RW'(PWM_INTERVAL);
    assign w_up   = RW'(r_step) * RW'(LSTEP);
    assign w_down = w_max - w_up;

    // Six-segment colour wheel: one channel full, one ramping, one off.
    always_comb begin
        w_raw_r = w_max;
        w_raw_g = w_up;
        w_raw_b = '0;
        case (r_seg)
            3'd1: begin w_raw_r = w_down; w_raw_g = w_max;  w_raw_b = '0;     end
            3'd2: begin w_raw_r = '0;     w_raw_g = w_max;  w_raw_b = w_up;   end
            3'd3: begin w_raw_r = '0;     w_raw_g = w_down; w_raw_b = w_max;  end
            3'd4: begin w_raw_r = w_up;   w_raw_g = '0;     w_raw_b = w_max;  end
            3'd5: begin w_raw_r = w_max;  w_raw_g = '0;     w_raw_b = w_down; end
            default: begin w_raw_r = w_max; w_raw_g = w_up; w_raw_b = '0;     end
        endcase
    end

    assign w_tgt_r = f_scale(w_raw_r, brightness);
    assign w_tgt_g = f_scale(w_raw_g, brightness);
    assign w_tgt_b = f_scale(w_raw_b, brightness);

    assign w_on_r = RW'(r_cnt) < r_duty_r;
    assign w_on_g = RW'(r_cnt) < r_duty_g;
    assign w_on_b = RW'(r_cnt) < r_duty_b;

    // Period counter, hue sequencer and duty reload at the period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_sdiv   <= '0;
            r_step   <= '0;
            r_seg    <= '0;
            r_duty_r <= '0;
            r_duty_g <= '0;
            r_duty_b <= '0;
        end else if (en) begin
            r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
            if (w_tick) begin
                r_duty_r <= w_tgt_r;
                r_duty_g <= w_tgt_g;
                r_duty_b <= w_tgt_b;
                if (!hold) begin
                    r_sdiv <= w_sdiv_wrap ? '0 : r_sdiv + SW'(1);
                    if (w_sdiv_wrap) begin
                        r_step <= w_step_wrap ? '0 : r_step + HW'(1);
                        if (w_step_wrap)
                            r_seg <= (r_seg == 3'd5) ? 3'd0 : r_seg + 3'd1;
                    end
                end
            end
        end
    end

    // Registered pin drivers; forced to the inactive level while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb_r <= AL;
            r_rgb_g <= AL;
            r_rgb_b <= AL;
        end else if (en) begin
            r_rgb_r <= w_on_r ^ AL;
            r_rgb_g <= w_on_g ^ AL;
            r_rgb_b <= w_on_b ^ AL;
        end else begin
            r_rgb_r <= AL;
            r_rgb_g <= AL;
            r_rgb_b <= AL;
        end
    end

    assign RGB_R       = r_rgb_r;
    assign RGB_G       = r_rgb_g;
    assign RGB_B       = r_rgb_b;
    assign segment     = r_seg;
    assign hue_step    = r_step;
    assign period_tick = w_tick;

endmodule
